sha3_axis_padder: RTL and testbench

Parametrised AXI-Stream front end for the SHA3 core. It accepts a raw byte message of arbitrary length and applies SHA3 padding in hardware (0x06 … 0x80). It repacks the message into rate-sized blocks of DATA_WIDTH words for the selected variant (224/256/384/512). It sits between the host AXI-Stream source and the Keccak absorber, replacing host-side padding and the fixed 16-bit, fixed-variant input path.

---
 rtl/sha3_pkg.sv | 24 ++
 rtl/sha3_pad_merge.sv | 32 +++
 rtl/sha3_axis_padder.sv | 137 +++++++++++++
 tb/tb_sha3_axis_padder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared SHA3 padder types and constants: variant encoding, rate table,
// padding byte values and the padder state encoding.
package sha3_pkg;

  typedef enum logic [1:0] {
    SHA3_224 = 2'd0,
    SHA3_256 = 2'd1,
    SHA3_384 = 2'd2,
    SHA3_512 = 2'd3
  } sha3_variant_t;

  // Rate in bytes, indexed by sha3_variant_t.
  localparam int unsigned SHA3_RATE_BYTES [4] = '{144, 136, 104, 72};

  localparam logic [7:0] SHA3_DS  = 8'h06;
  localparam logic [7:0] SHA3_END = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ABSORB = 2'd1,
    ST_PAD    = 2'd2
  } sha3_state_t;

endpackage

// File: rtl/sha3_pad_merge.sv
// Combinational padding merge: keeps the low n bytes of a word, places the
// domain-separation byte at byte n and optionally closes the block with 0x80.
module sha3_pad_merge
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NW         = $clog2(DATA_WIDTH / 8 + 1)
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [NW-1:0]         n,
  input  logic                  pad_first,
  input  logic                  is_last_word,
  output logic [DATA_WIDTH-1:0] padded
);

  localparam int B = DATA_WIDTH / 8;

  always_comb begin
    padded = '0;
    for (int i = 0; i < B; i++) begin
      if (i < int'(n)) begin
        padded[8*i +: 8] = word[8*i +: 8];
      end else if (i == int'(n) && pad_first) begin
        padded[8*i +: 8] = SHA3_DS;
      end
    end
    if (is_last_word) begin
      padded[DATA_WIDTH-1 -: 8] = padded[DATA_WIDTH-1 -: 8] | SHA3_END;
    end
  end

endmodule

// File: rtl/sha3_axis_padder.sv
// AXI-Stream SHA3 padder: forwards message words, appends 0x06..0x80 padding
// and frames the output into rate-sized blocks for the latched variant.
module sha3_axis_padder
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [1:0]              s_axis_tuser,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic [2:0]              m_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output sha3_state_t             dbg_state
);

  localparam int B  = DATA_WIDTH / 8;
  localparam int NW = $clog2(B + 1);

  localparam logic [7:0] LAST_IDX [4] = '{
    8'(SHA3_RATE_BYTES[0] / B - 1), 8'(SHA3_RATE_BYTES[1] / B - 1),
    8'(SHA3_RATE_BYTES[2] / B - 1), 8'(SHA3_RATE_BYTES[3] / B - 1)
  };

  sha3_state_t   state_q, state_d;
  sha3_variant_t variant_q;
  logic          pad_first_q, pad_first_d;
  logic [7:0]    word_cnt_q;

  logic [1:0]            variant_eff;
  logic                  out_free, in_fire, pad_fire, at_last, short_last, close_blk;
  logic [NW-1:0]         n_in, merge_n;
  logic [DATA_WIDTH-1:0] merge_word, merged;
  logic                  merge_pf;

  // Number of contiguous valid bytes from byte 0; bytes above a gap are ignored.
  function automatic logic [NW-1:0] keep_run(input logic [B-1:0] keep);
    logic [NW-1:0] cnt;
    logic          run;
    cnt = '0;
    run = 1'b1;
    for (int i = 0; i < B; i++) begin
      run = run & keep[i];
      cnt = cnt + NW'(run);
    end
    return cnt;
  endfunction

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The single output register accepts a new word when empty or draining
  // (!m_axis_tvalid || m_axis_tready); input is stalled while padding.
  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state_q != ST_PAD) && out_free;
  assign in_fire       = s_axis_tvalid && s_axis_tready;
  assign pad_fire      = (state_q == ST_PAD) && out_free;
  assign variant_eff   = (state_q == ST_IDLE) ? s_axis_tuser : variant_q;
  assign at_last       = (word_cnt_q == LAST_IDX[variant_eff]);
  assign n_in          = s_axis_tlast ? keep_run(s_axis_tkeep) : NW'(B);
  assign short_last    = s_axis_tlast && (n_in < NW'(B));
  assign close_blk     = at_last && ((state_q == ST_PAD) || short_last);
  assign dbg_state     = state_q;

  assign merge_word = (state_q == ST_PAD) ? '0 : s_axis_tdata;
  assign merge_n    = (state_q == ST_PAD) ? '0 : n_in;
  assign merge_pf   = (state_q == ST_PAD) ? pad_first_q : 1'b1;

  sha3_pad_merge #(.DATA_WIDTH(DATA_WIDTH), .NW(NW)) u_merge (
    .word         (merge_word),
    .n            (merge_n),
    .pad_first    (merge_pf),
    .is_last_word (close_blk),
    .padded       (merged)
  );

  always_comb begin
    state_d     = state_q;
    pad_first_d = pad_first_q;
    case (state_q)
      ST_IDLE, ST_ABSORB: begin
        if (in_fire) begin
          if (!s_axis_tlast) begin
            state_d = ST_ABSORB;
          end else if (short_last) begin
            state_d     = at_last ? ST_IDLE : ST_PAD;
            pad_first_d = 1'b0;
          end else begin
            state_d     = ST_PAD;
            pad_first_d = 1'b1;
          end
        end
      end
      ST_PAD: begin
        if (pad_fire) begin
          pad_first_d = 1'b0;
          if (at_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q       <= ST_IDLE;
      variant_q     <= SHA3_224;
      pad_first_q   <= 1'b0;
      word_cnt_q    <= '0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      state_q     <= state_d;
      pad_first_q <= pad_first_d;
      if (in_fire && state_q == ST_IDLE) begin
        variant_q <= sha3_variant_t'(s_axis_tuser);
      end
      if (in_fire || pad_fire) begin
        m_axis_tdata  <= merged;
        m_axis_tlast  <= at_last;
        m_axis_tuser  <= {variant_eff, close_blk};
        m_axis_tvalid <= 1'b1;
        word_cnt_q    <= at_last ? 8'd0 : word_cnt_q + 8'd1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha3_axis_padder.sv
// Directed bench for sha3_axis_padder at DATA_WIDTH = 16: message table,
// byte-level padding model feeding a word scoreboard, plus stall and reset sequences.
module tb_sha3_axis_padder;
  import sha3_pkg::*;

  localparam int DW = 16;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic [DW-1:0] s_axis_tdata;
  logic [1:0]    s_axis_tkeep;
  logic [1:0]    s_axis_tuser;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [2:0]    m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  sha3_state_t   dbg_state;

  sha3_axis_padder #(.DATA_WIDTH(DW)) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  typedef struct {
    int          len;
    logic [7:0]  start;
    logic [1:0]  variant;
    bit          junk;
    int          exp_words;
    logic [15:0] exp_final;
  } vec_t;

  vec_t        vecs [10];
  logic [19:0] exp_q [$];   // {tdata, tlast, tuser}
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          sb_en    = 0;
  bit          stab_en  = 0;
  bit          rdy_mode = 0;
  int          out_cnt  = 0;
  logic [15:0] last_out = '0;
  bit          stall_seen = 0;
  logic [19:0] held, got, exp_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, act, exp);
  endtask

  function automatic int rate_of(input logic [1:0] v);
    case (v)
      2'd0:    return 144;
      2'd1:    return 136;
      2'd2:    return 104;
      default: return 72;
    endcase
  endfunction

  // Byte-level reference: message, 0x06, zero fill to a rate multiple, 0x80 on the last byte.
  task automatic build_expected(input int len, input logic [7:0] start, input logic [1:0] v);
    int r, p;
    logic [7:0] pb [];
    r  = rate_of(v);
    p  = (len / r + 1) * r;
    pb = new[p];
    for (int i = 0; i < p; i++)
      pb[i] = (i < len) ? 8'(start + i) : ((i == len) ? 8'h06 : 8'h00);
    pb[p-1] = pb[p-1] | 8'h80;
    for (int k = 0; k < p / 2; k++)
      exp_q.push_back({pb[2*k+1], pb[2*k], ((2*k+2) % r == 0), v, (k == p/2 - 1)});
  endtask

  // Driver tasks: entered and left at posedge + 1.
  task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input logic [1:0] u,
                           input logic l);
    int  t;
    bit  rdy;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    t = 0;
    forever begin
      @(negedge ACLK);
      rdy = s_axis_tready;
      @(posedge ACLK);
      #1;
      if (rdy) break;
      t++;
      if (t > 300) begin
        n_checks++;
        $display("FAIL send_timeout s_axis_tready stuck at 0, expected 1");
        break;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_msg(input int len, input logic [7:0] start, input logic [1:0] v,
                          input bit junk);
    int full, rem;
    full = len / 2;
    rem  = len % 2;
    if (len == 0 && !junk) begin
      send_beat(16'hBEEF, 2'b00, v, 1'b1);
      return;
    end
    for (int k = 0; k < full; k++)
      send_beat({8'(start + 2*k + 1), 8'(start + 2*k)}, 2'b11, (k == 0) ? v : ~v,
                (k == full - 1) && rem == 0 && !junk);
    if (rem != 0) send_beat({8'h5A, 8'(start + len - 1)}, 2'b01, (full == 0) ? v : ~v, 1'b1);
    if (junk)     send_beat(16'hFFEE, 2'b10, ~v, 1'b1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge ACLK);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout remaining=%0d expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge ACLK);
    #1;
  endtask

  // m_axis_tready: always high, or alternating 1,0,1,0 per cycle.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge ACLK);
      #1;
      m_axis_tready = rdy_mode ? ~m_axis_tready : 1'b1;
    end
  end

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge ACLK) begin
    if (sb_en) begin
      got = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
      if (stab_en && stall_seen) begin
        check("stall_hold_word", 32'(got), 32'(held));
        check("stall_hold_valid", 32'(m_axis_tvalid), 32'd1);
      end
      stall_seen = m_axis_tvalid && !m_axis_tready;
      held       = got;
      if (m_axis_tvalid && m_axis_tready) begin
        out_cnt++;
        last_out = m_axis_tdata;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_word got=%h expected none", got);
        end else begin
          exp_w = exp_q.pop_front();
          check($sformatf("word%0d", out_cnt - 1), 32'(got), 32'(exp_w));
        end
      end
    end
  end

  initial begin
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    ARESETn       = 1'b0;

    //            len  start  var  junk words final
    vecs[0] = '{  0, 8'h00, 2'd1, 1'b0, 68,  16'h8000};  // empty, SHA3-256
    vecs[1] = '{  3, 8'h61, 2'd1, 1'b0, 68,  16'h8000};  // "abc"
    vecs[2] = '{136, 8'h00, 2'd1, 1'b0, 136, 16'h8000};  // exact rate, extra pad block
    vecs[3] = '{135, 8'h25, 2'd1, 1'b0, 68,  16'h86AB};  // single pad byte
    vecs[4] = '{ 71, 8'h87, 2'd3, 1'b0, 36,  16'h86CD};  // single pad byte, SHA3-512
    vecs[5] = '{  1, 8'h11, 2'd0, 1'b0, 72,  16'h8000};  // SHA3-224
    vecs[6] = '{104, 8'h03, 2'd2, 1'b0, 104, 16'h8000};  // SHA3-384 exact rate
    vecs[7] = '{  2, 8'h40, 2'd1, 1'b1, 68,  16'h8000};  // tlast keep=10 -> n=0
    vecs[8] = '{271, 8'h00, 2'd1, 1'b0, 136, 16'h860E};  // two blocks, single pad byte
    vecs[9] = '{ 70, 8'h20, 2'd3, 1'b0, 36,  16'h8006};  // full last beat on word34

    repeat (3) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tlast",  32'(m_axis_tlast),  32'd0);
    check("rst_m_tuser",  32'(m_axis_tuser),  32'd0);
    check("rst_m_tdata",  32'(m_axis_tdata),  32'd0);
    check("rst_s_tready", 32'(s_axis_tready), 32'd1);
    check("rst_state",    32'(dbg_state),     32'(ST_IDLE));
    @(posedge ACLK);
    #1;
    sb_en = 1;

    for (int i = 0; i < 10; i++) begin
      out_cnt = 0;
      build_expected(vecs[i].len, vecs[i].start, vecs[i].variant);
      send_msg(vecs[i].len, vecs[i].start, vecs[i].variant, vecs[i].junk);
      wait_drain();
      check($sformatf("vec%0d_words", i), 32'(out_cnt), 32'(vecs[i].exp_words));
      check($sformatf("vec%0d_final", i), 32'(last_out), 32'(vecs[i].exp_final));
    end

    // back-to-back messages, next first beat right behind the final word
    out_cnt = 0;
    build_expected(3, 8'h61, 2'd1);
    build_expected(0, 8'h00, 2'd2);
    send_msg(3, 8'h61, 2'd1, 1'b0);
    send_msg(0, 8'h00, 2'd2, 1'b0);
    wait_drain();
    check("b2b_words", 32'(out_cnt), 32'd120);

    // back-pressure 1,0,1,0 across "abc"
    rdy_mode = 1;
    stab_en  = 1;
    out_cnt  = 0;
    build_expected(3, 8'h61, 2'd1);
    send_msg(3, 8'h61, 2'd1, 1'b0);
    wait_drain();
    check("bp_words", 32'(out_cnt), 32'd68);
    stab_en  = 0;
    rdy_mode = 0;
    repeat (2) @(posedge ACLK);
    #1;

    // reset pulse while padding
    sb_en = 0;
    send_msg(3, 8'h61, 2'd1, 1'b0);
    repeat (5) @(posedge ACLK);
    #1;
    check("pre_rst_state", 32'(dbg_state), 32'(ST_PAD));
    ARESETn = 1'b0;
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("midrst_s_tready", 32'(s_axis_tready), 32'd1);
    check("midrst_state",    32'(dbg_state),     32'(ST_IDLE));
    @(posedge ACLK);
    #1;
    exp_q.delete();
    stall_seen = 0;
    sb_en      = 1;
    out_cnt    = 0;
    build_expected(0, 8'h00, 2'd3);
    send_msg(0, 8'h00, 2'd3, 1'b0);
    wait_drain();
    check("post_rst_words", 32'(out_cnt), 32'd36);
    check("post_rst_final", 32'(last_out), 32'h8000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
